uart_runner: RTL and testbench



---
 rtl/uart_runner.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_runner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_runner.sv
// uart_runner: 8N1 UART transceiver with a byte valid/ready transmit path and a byte valid-pulse receive path.
// Latency: the start bit leaves on the cycle after acceptance; rx_valid_o pulses 1 cycle after the stop-bit midpoint (2-flop sync ahead of RX).
// Backpressure: tx_ready_o is low for the whole frame and requests during a frame are dropped; RX has none, a new byte overwrites the old.
// Build option UART_LOOPBACK_EN: feeds the registered tx_o into the RX synchronizer and ignores rx_i.
module uart_runner #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ---------------------------------------------------------------- TX
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
    logic [2:0]      tx_bit_q,   tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_line_q,  tx_line_d;

    // TX state register; the line idles high so a reset mid-frame releases it at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state: the next line level is computed here so tx_o comes straight from a flop
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    tx_shift_d = tx_data_i;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign tx_ready_o = (tx_state_q == ST_IDLE);
    assign tx_o       = tx_line_q;

    // ---------------------------------------------------------------- RX
    logic rx_src;
`ifdef UART_LOOPBACK_EN
    assign rx_src = tx_line_q;
`else
    assign rx_src = rx_i;
`endif

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_src;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_bit_q,   rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q,  rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            ferr_q,     ferr_d;

    // RX state register and registered result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // RX next state: half a bit to the start midpoint, then one full bit between samples
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A line that is already high again was a glitch, not a start bit
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_runner.sv
// Directed-plus-random bench for uart_runner: frames built from the 8N1 rule, received bytes kept in queues.
module tb_uart_runner;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       tx_o;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;

    logic       lb_sel;
    logic       rx_drv;

    int         checks = 0;
    int         errors = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_idx = 0;
    int         ferr_cnt = 0;
    int         exp_ferr = 0;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    // External loop so loopback scenarios run in either build
    assign rx_i = lb_sel ? tx_o : rx_drv;

    uart_runner #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_o       (tx_o),
        .rx_i       (rx_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .frame_err_o(frame_err_o)
    );

    // Receive monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid_o) got_q.push_back(rx_data_o);
        if (frame_err_o) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one byte and check its waveform bit by bit; optionally poke a new request mid-frame
    task automatic send_byte(input logic [7:0] b, input bit inject);
        int n = 0;
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        while (!tx_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready_o, 1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
        exp_q.push_back(b);
        for (int c = 0; c <= 10 * CPB; c++) begin
            @(negedge clk);
            if (inject && c == 40) begin
                tx_data_i  = 8'h55;
                tx_valid_i = 1'b1;
            end
            if (inject && c == 60) tx_valid_i = 1'b0;
            if (c == 0) check("tx_ready_drop", tx_ready_o, 0);
            if (c % CPB == CPB / 2) check($sformatf("tx_bit%0d", c / CPB), tx_o, frame[c / CPB]);
            if (c == 10 * CPB - 1) check("tx_ready_busy", tx_ready_o, 0);
            if (c == 10 * CPB) check("tx_ready_back", tx_ready_o, 1);
        end
        last_good = b;
    endtask

    // Compare every expected byte against what the monitor captured, then demand nothing extra
    task automatic check_rx(input string tag);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) begin
                check({tag, "_data"}, got_q[rd_idx], e);
                rd_idx++;
            end else begin
                check({tag, "_count"}, got_q.size(), rd_idx + 1);
            end
        end
        check({tag, "_extra"}, got_q.size(), rd_idx);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    endtask

    // Drive a serial frame straight onto rx_i
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        rst_n      = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        lb_sel     = 1'b1;
        rx_drv     = 1'b1;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_tx_o", tx_o, 1);
        check("rst_tx_ready", tx_ready_o, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tx_o", tx_o, 1);
        check("rel_tx_ready", tx_ready_o, 1);
        check("rel_rx_data", rx_data_o, 8'h00);
        check("rel_rx_valid", rx_valid_o, 0);
        check("rel_frame_err", frame_err_o, 0);

        // Single byte through the loop
        send_byte(8'hAC, 1'b0);
        repeat (100) @(negedge clk);
        check_rx("lb_ac");
        check("lb_ac_out", rx_data_o, 8'hAC);

        // Back-to-back extremes
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (120) @(negedge clk);
        check_rx("b2b");

        // Request while busy is dropped
        send_byte(8'hAC, 1'b1);
        repeat (120) @(negedge clk);
        check_rx("busy_ignore");

        // Random bytes with random gaps
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send_byte(rb, 1'b0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (120) @(negedge clk);
        check_rx("rand_lb");

`ifndef UART_LOOPBACK_EN
        // Direct line: glitch, bad stop bit, then random frames
        lb_sel = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_rx("false_start");

        drive_frame(8'h3C, 1'b0);
        check_rx("bad_stop");
        check("bad_stop_hold", rx_data_o, last_good);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            drive_frame(rb, 1'($urandom_range(0, 3) != 0));
        end
        check_rx("rand_rx");
        check("rand_rx_out", rx_data_o, last_good);
        lb_sel = 1'b1;
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a low data bit
        tx_data_i  = 8'hAC;
        tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_tx_low", tx_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tx_o", tx_o, 1);
        check("async_tx_ready", tx_ready_o, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        @(negedge clk);
        check("post_rst_rx_data", rx_data_o, last_good);
        send_byte(8'hAC, 1'b0);
        repeat (120) @(negedge clk);
        check_rx("post_rst");
        check("post_rst_out", rx_data_o, 8'hAC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
